// File: rtl/bb_shared_reg_arb.sv
// Round-robin arbiter sharing one DW-bit register among NREQ requesters (LOAD/SET/CLEAR/NOP).
// Optional ownership lock enabled by defining SHARED_REG_LOCK_EN.
module bb_shared_reg_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned SET_VAL = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [2*NREQ-1:0]        op_i,
  input  logic [NREQ*DW-1:0]       din_i,
`ifdef SHARED_REG_LOCK_EN
  input  logic [NREQ-1:0]          lock_i,
`endif
  output logic [NREQ-1:0]          gnt_o,
  output logic [$clog2(NREQ)-1:0]  owner_o,
  output logic                     upd_o,
  output logic [DW-1:0]            dout_o
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [DW-1:0] RstV = DW'(RST_VAL);
  localparam logic [DW-1:0] SetV = DW'(SET_VAL);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [NREQ-1:0] gnt_q;
  logic            upd_q;
  logic [DW-1:0]   dout_q;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   sel_idx;
  logic            grant_en;
  logic [1:0]      sel_op;
  logic [DW-1:0]   dout_d;
  logic            upd_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   ptr_inc;

  // Rotating search: first requester at or after the pointer wins.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_idx  = win;
    grant_en = found;
`ifdef SHARED_REG_LOCK_EN
    if (state_q == StLocked) begin
      sel_idx  = owner_q;
      grant_en = req_i[owner_q];
    end
`endif
    sel_op = op_i[2*sel_idx +: 2];
    upd_d  = (sel_op != 2'b11);
    unique case (sel_op)
      2'b00:   dout_d = din_i[DW*sel_idx +: DW];
      2'b01:   dout_d = SetV;
      2'b10:   dout_d = RstV;
      default: dout_d = dout_q;
    endcase
    gnt_d          = '0;
    gnt_d[sel_idx] = 1'b1;
    ptr_inc        = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StArb;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      upd_q   <= 1'b0;
      dout_q  <= RstV;
    end else begin
      gnt_q <= '0;
      upd_q <= 1'b0;
      unique case (state_q)
        StArb: begin
          if (grant_en) begin
            gnt_q   <= gnt_d;
            upd_q   <= upd_d;
            dout_q  <= dout_d;
            owner_q <= sel_idx;
            ptr_q   <= ptr_inc;
`ifdef SHARED_REG_LOCK_EN
            if (lock_i[sel_idx]) state_q <= StLocked;
`endif
          end
        end
`ifdef SHARED_REG_LOCK_EN
        StLocked: begin
          // Pointer stays frozen while the owner keeps its lock.
          if (grant_en) begin
            gnt_q  <= gnt_d;
            upd_q  <= upd_d;
            dout_q <= dout_d;
            if (!lock_i[owner_q]) begin
              state_q <= StArb;
              ptr_q   <= ptr_inc;
            end
          end else begin
            state_q <= StArb;
            ptr_q   <= ptr_inc;
          end
        end
`endif
        default: state_q <= StArb;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign upd_o   = upd_q;
  assign dout_o  = dout_q;

endmodule

// File: tb/tb_bb_shared_reg_arb.sv
// Self-checking bench for bb_shared_reg_arb: behavioural model compared every cycle plus
// directed literal checks. Lock scenario runs when SHARED_REG_LOCK_EN is defined.
module tb_bb_shared_reg_arb;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [2*NREQ-1:0] op;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]  lock;
  logic [NREQ-1:0]  gnt;
  logic [1:0]       owner;
  logic             upd;
  logic [DW-1:0]    dout;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  bb_shared_reg_arb #(.NREQ(NREQ), .DW(DW), .RST_VAL(0), .SET_VAL(1)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .op_i   (op),
    .din_i  (din),
`ifdef SHARED_REG_LOCK_EN
    .lock_i (lock),
`endif
    .gnt_o  (gnt),
    .owner_o(owner),
    .upd_o  (upd),
    .dout_o (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs after each edge, from the arbitration rules directly.
  logic [NREQ-1:0] e_gnt;
  logic            e_upd;
  logic [DW-1:0]   e_dout;
  int              m_ptr, m_owner;
  bit              m_locked;

  function automatic void m_apply(input int w);
    int opc;
    opc    = (op >> (2 * w)) & 3;
    e_gnt  = 4'(1 << w);
    e_upd  = (opc != 3);
    case (opc)
      0: e_dout = din[DW*w +: DW];
      1: e_dout = 8'd1;
      2: e_dout = 8'd0;
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    int w;
    e_gnt = '0;
    e_upd = 1'b0;
    if (rst) begin
      e_dout = '0; m_ptr = 0; m_owner = 0; m_locked = 0;
    end else if (m_locked) begin
      if (req[m_owner]) begin
        m_apply(m_owner);
        if (!lock[m_owner]) begin m_locked = 0; m_ptr = (m_owner + 1) % NREQ; end
      end else begin
        m_locked = 0; m_ptr = (m_owner + 1) % NREQ;
      end
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_apply(w);
        m_owner = w;
        m_ptr   = (w + 1) % NREQ;
        if (lock[w]) m_locked = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_gnt", 32'(gnt), 32'(e_gnt));
      chk("mon_upd", 32'(upd), 32'(e_upd));
      chk("mon_dout", 32'(dout), 32'(e_dout));
      chk("mon_owner", 32'(owner), 32'(m_owner));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [3:0] g, input logic u, input logic [7:0] d);
    chk({name, "_gnt"}, 32'(gnt), 32'(g));
    chk({name, "_upd"}, 32'(upd), 32'(u));
    chk({name, "_dout"}, 32'(dout), 32'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; op = '0; din = 32'h03020100; lock = '0;
    // Reset overrides pending requests
    tick(); mon_en = 1'b1;
    lit("rst1", 4'b0000, 1'b0, 8'h00); chk("rst1_owner", 32'(owner), 0);
    tick();
    lit("rst2", 4'b0000, 1'b0, 8'h00); chk("rst2_owner", 32'(owner), 0);
    rst = 1'b0; req = '0; tick();
    lit("rel", 4'b0000, 1'b0, 8'h00); chk("rel_owner", 32'(owner), 0);

    // Single LOAD
    req = 4'b0001; op = 8'b11111100; din = 32'h000000A5; tick();
    lit("load", 4'b0001, 1'b1, 8'hA5); chk("load_owner", 32'(owner), 0);
    req = '0; tick();
    lit("idle", 4'b0000, 1'b0, 8'hA5);

    // Full round robin, all LOAD din_i = i
    do_reset();
    req = 4'b1111; op = '0; din = 32'h03020100;
    for (int i = 0; i < 5; i++) begin
      tick();
      lit($sformatf("rr%0d", i), 4'(1 << (i % 4)), 1'b1, 8'(i % 4));
    end

    // SET then CLEAR with dout preloaded to 55 and pointer at 0
    do_reset();
    req = 4'b1000; op = '0; din = 32'h55000000; tick();
    lit("pre55", 4'b1000, 1'b1, 8'h55);
    req = 4'b0110; op = 8'b00_10_01_00; tick();
    lit("set", 4'b0010, 1'b1, 8'h01);
    tick();
    lit("clr", 4'b0100, 1'b1, 8'h00);

    // NOP grant leaves value alone; reset beats pending request
    req = 4'b0001; op = 8'b00000000; din = 32'h0000003C; tick();
    lit("ld3c", 4'b0001, 1'b1, 8'h3C);
    op = 8'b00000011; tick();
    lit("nop", 4'b0001, 1'b0, 8'h3C);
    rst = 1'b1; req = 4'b1000; op = '0; tick(); rst = 1'b0;
    lit("rstpend", 4'b0000, 1'b0, 8'h00); chk("rstpend_owner", 32'(owner), 0);
    req = '0; tick();

`ifdef SHARED_REG_LOCK_EN
    do_reset();
    req = 4'b0011; op = '0; din = 32'h00002211; lock = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick(); lit($sformatf("lock%0d", i), 4'b0001, 1'b1, 8'h11);
    end
    lock = '0; tick(); lit("unlock", 4'b0001, 1'b1, 8'h11);
    tick(); lit("after", 4'b0010, 1'b1, 8'h22);
    req = '0; tick();
`endif

    // Broad model-checked sweep
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      req = 4'($urandom);
      op  = 8'($urandom);
      din = $urandom;
`ifdef SHARED_REG_LOCK_EN
      lock = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
`endif
      tick();
    end
    rst = 1'b0; req = '0; lock = '0; tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
